// File: rtl/uart_servo_cmd_decoder_pkg.sv
// Shared definitions for the framed servo command decoder:
// default sync marker, error codes, FSM states and the angle clamp helper.
package uart_servo_cmd_decoder_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CSUM = 2'b01,
        ERR_ID   = 2'b10,
        ERR_TMO  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        S_SYNC  = 2'b00,
        S_ID    = 2'b01,
        S_ANGLE = 2'b10,
        S_CHECK = 2'b11
    } state_e;

    // Unsigned clamp of a requested angle into [lo, hi].
    function automatic logic [7:0] clamp_angle(input logic [7:0] a,
                                               input logic [7:0] lo,
                                               input logic [7:0] hi);
        if (a < lo) begin
            return lo;
        end else if (a > hi) begin
            return hi;
        end else begin
            return a;
        end
    endfunction

endpackage

// File: rtl/uart_servo_cmd_decoder.sv
// Framed servo command decoder: sync / id / angle / xor-checksum frames from a
// byte-strobe stream, with inter-byte timeout, clamping and per-frame status.
module uart_servo_cmd_decoder
    import uart_servo_cmd_decoder_pkg::*;
#(
    parameter int unsigned N_MOTORS       = 6,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned ANGLE_MIN      = 0,
    parameter int unsigned ANGLE_MAX      = 180,
    parameter int unsigned ANGLE_RESET    = 90
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [8*N_MOTORS-1:0]   angles,
    output logic                    upd_valid,
    output logic [7:0]              upd_id,
    output logic                    frame_err,
    output logic [1:0]              err_code,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [7:0]      id_q, id_d;
    logic [7:0]      ang_q, ang_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      angles_q [N_MOTORS];
    logic [7:0]      angles_d [N_MOTORS];
    logic            upd_valid_q, upd_valid_d;
    logic [7:0]      upd_id_q, upd_id_d;
    logic            frame_err_q, frame_err_d;
    err_code_e       err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [7:0]      ang_clamped;

    assign ang_clamped = clamp_angle(ang_q, 8'(ANGLE_MIN), 8'(ANGLE_MAX));

    // Next-state logic: frame parsing, validation, commit and timeout.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        ang_d       = ang_q;
        tmo_d       = tmo_q;
        upd_valid_d = 1'b0;
        upd_id_d    = upd_id_q;
        frame_err_d = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        for (int unsigned k = 0; k < N_MOTORS; k++) begin
            angles_d[k] = angles_q[k];
        end

        if (state_q == S_SYNC) begin
            tmo_d = '0;
            if (rx_valid && rx_data == SYNC_BYTE) begin
                state_d = S_ID;
            end
        end else if (rx_valid) begin
            // A byte in the expiry cycle is accepted, so it is tested first.
            tmo_d = '0;
            unique case (state_q)
                S_ID: begin
                    id_d    = rx_data;
                    state_d = S_ANGLE;
                end
                S_ANGLE: begin
                    ang_d   = rx_data;
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    state_d = S_SYNC;
                    if (rx_data != (id_q ^ ang_q)) begin
                        frame_err_d = 1'b1;
                        err_d       = ERR_CSUM;
                    end else if (32'(id_q) >= N_MOTORS) begin
                        frame_err_d = 1'b1;
                        err_d       = ERR_ID;
                    end else begin
                        upd_valid_d = 1'b1;
                        upd_id_d    = id_q;
                        cnt_d       = cnt_q + 16'd1;
                        for (int unsigned k = 0; k < N_MOTORS; k++) begin
                            if (id_q == 8'(k)) begin
                                angles_d[k] = ang_clamped;
                            end
                        end
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end else if (tmo_q == TMO_LAST) begin
            state_d     = S_SYNC;
            tmo_d       = '0;
            id_d        = '0;
            ang_d       = '0;
            frame_err_d = 1'b1;
            err_d       = ERR_TMO;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // State and registered outputs; async reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SYNC;
            id_q        <= '0;
            ang_q       <= '0;
            tmo_q       <= '0;
            upd_valid_q <= 1'b0;
            upd_id_q    <= '0;
            frame_err_q <= 1'b0;
            err_q       <= ERR_NONE;
            cnt_q       <= '0;
            for (int unsigned k = 0; k < N_MOTORS; k++) begin
                angles_q[k] <= 8'(ANGLE_RESET);
            end
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            ang_q       <= ang_d;
            tmo_q       <= tmo_d;
            upd_valid_q <= upd_valid_d;
            upd_id_q    <= upd_id_d;
            frame_err_q <= frame_err_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            for (int unsigned k = 0; k < N_MOTORS; k++) begin
                angles_q[k] <= angles_d[k];
            end
        end
    end

    // Flatten the angle registers onto the output bus, motor k at [8k+7:8k].
    always_comb begin
        angles = '0;
        for (int unsigned k = 0; k < N_MOTORS; k++) begin
            angles[8*k +: 8] = angles_q[k];
        end
    end

    assign upd_valid = upd_valid_q;
    assign upd_id    = upd_id_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_servo_cmd_decoder.sv
// Directed self-checking bench for uart_servo_cmd_decoder
// (N_MOTORS=6, ANGLE_MIN=10, ANGLE_MAX=180, TIMEOUT_CYCLES=16).
module tb_uart_servo_cmd_decoder;

    localparam int unsigned NM = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [8*NM-1:0]   angles;
    logic              upd_valid;
    logic [7:0]        upd_id;
    logic              frame_err;
    logic [1:0]        err_code;
    logic [15:0]       frame_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_ang [NM];

    uart_servo_cmd_decoder #(
        .N_MOTORS       (NM),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16),
        .ANGLE_MIN      (10),
        .ANGLE_MAX      (180),
        .ANGLE_RESET    (90)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .angles    (angles),
        .upd_valid (upd_valid),
        .upd_id    (upd_id),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*NM-1:0] exp_bus();
        logic [8*NM-1:0] b;
        for (int k = 0; k < NM; k++) b[8*k +: 8] = exp_ang[k];
        return b;
    endfunction

    // Entered on a falling edge; drives one byte for one cycle and returns
    // on the next falling edge, where that byte's effect is visible.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] ang, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(id);
        send_byte(ang);
        send_byte(cs);
    endtask

    task automatic reset_model();
        for (int k = 0; k < NM; k++) exp_ang[k] = 8'd90;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reset_model();
        idle(3);
        check("rst_angles",    64'(angles),    64'(exp_bus()));
        check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_upd_id",    64'(upd_id),    64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_err_code",  64'(err_code),  64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Plain commit to slot 2
        send_frame(8'h02, 8'h64, 8'h66);
        exp_ang[2] = 8'd100;
        check("f1_upd_valid", 64'(upd_valid), 64'd1);
        check("f1_upd_id",    64'(upd_id),    64'd2);
        check("f1_angles",    64'(angles),    64'(exp_bus()));
        check("f1_frame_cnt", 64'(frame_cnt), 64'd1);
        check("f1_frame_err", 64'(frame_err), 64'd0);
        idle(1);
        check("f1_upd_pulse", 64'(upd_valid), 64'd0);

        // Clamp high: 200 -> 180
        send_frame(8'h01, 8'hC8, 8'hC9);
        exp_ang[1] = 8'd180;
        check("f2_upd_id",    64'(upd_id),    64'd1);
        check("f2_angles",    64'(angles),    64'(exp_bus()));
        check("f2_frame_cnt", 64'(frame_cnt), 64'd2);

        // Clamp low: 5 -> 10, back-to-back with previous frame
        send_frame(8'h00, 8'h05, 8'h05);
        exp_ang[0] = 8'd10;
        check("f3_upd_valid", 64'(upd_valid), 64'd1);
        check("f3_angles",    64'(angles),    64'(exp_bus()));
        check("f3_frame_cnt", 64'(frame_cnt), 64'd3);

        // Bad checksum
        send_frame(8'h03, 8'h50, 8'h00);
        check("csum_frame_err", 64'(frame_err), 64'd1);
        check("csum_err_code",  64'(err_code),  64'd1);
        check("csum_upd_valid", 64'(upd_valid), 64'd0);
        check("csum_angles",    64'(angles),    64'(exp_bus()));
        check("csum_frame_cnt", 64'(frame_cnt), 64'd3);
        idle(1);
        check("csum_err_pulse", 64'(frame_err), 64'd0);
        check("csum_err_hold",  64'(err_code),  64'd1);

        // Out-of-range id (valid checksum)
        send_frame(8'h06, 8'h10, 8'h16);
        check("id_frame_err", 64'(frame_err), 64'd1);
        check("id_err_code",  64'(err_code),  64'd2);
        check("id_upd_valid", 64'(upd_valid), 64'd0);
        check("id_angles",    64'(angles),    64'(exp_bus()));

        // Non-sync noise is dropped silently, then a good frame
        send_byte(8'h00);
        send_byte(8'hFF);
        check("noise_frame_err", 64'(frame_err), 64'd0);
        send_byte(8'h5A);
        check("noise_err_hold",  64'(err_code),  64'd2);
        send_frame(8'h04, 8'h1E, 8'h1A);
        exp_ang[4] = 8'd30;
        check("f4_upd_valid", 64'(upd_valid), 64'd1);
        check("f4_angles",    64'(angles),    64'(exp_bus()));
        check("f4_frame_cnt", 64'(frame_cnt), 64'd4);

        // Timeout: 16 idle cycles after the id byte
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(15);
        check("tmo_not_yet", 64'(frame_err), 64'd0);
        idle(1);
        check("tmo_frame_err", 64'(frame_err), 64'd1);
        check("tmo_err_code",  64'(err_code),  64'd3);
        check("tmo_angles",    64'(angles),    64'(exp_bus()));
        // Back in sync hunting: a complete frame commits
        send_frame(8'h05, 8'h2D, 8'h28);
        exp_ang[5] = 8'd45;
        check("f5_upd_valid", 64'(upd_valid), 64'd1);
        check("f5_angles",    64'(angles),    64'(exp_bus()));
        check("f5_frame_cnt", 64'(frame_cnt), 64'd5);

        // Byte arriving in the expiry cycle is accepted
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(15);
        send_byte(8'h3C);
        check("late_no_tmo", 64'(frame_err), 64'd0);
        send_byte(8'h3D);
        exp_ang[1] = 8'd60;
        check("late_upd_valid", 64'(upd_valid), 64'd1);
        check("late_angles",    64'(angles),    64'(exp_bus()));
        check("late_frame_cnt", 64'(frame_cnt), 64'd6);

        // Reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h03);
        rst_n = 1'b0;
        #1;
        reset_model();
        check("mid_rst_angles",    64'(angles),    64'(exp_bus()));
        check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("mid_rst_upd_id",    64'(upd_id),    64'd0);
        check("mid_rst_err_code",  64'(err_code),  64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_frame(8'h03, 8'h50, 8'h53);
        exp_ang[3] = 8'd80;
        check("f6_upd_valid", 64'(upd_valid), 64'd1);
        check("f6_upd_id",    64'(upd_id),    64'd3);
        check("f6_angles",    64'(angles),    64'(exp_bus()));
        check("f6_frame_cnt", 64'(frame_cnt), 64'd1);
        check("f6_frame_err", 64'(frame_err), 64'd0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
